// File: rtl/display_scan_driver_pkg.sv
// Shared types and constants for the two-digit 7-segment scan driver.
// Segment codes are active-high {g,f,e,d,c,b,a}.
package display_pkg;

    typedef enum logic {
        S_UNITS = 1'b0,
        S_TENS  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [3:0] units_of(input logic [3:0] v);
        return (v >= 4'd10) ? (v - 4'd10) : v;
    endfunction

    function automatic logic tens_of(input logic [3:0] v);
        return (v >= 4'd10);
    endfunction

endpackage

// File: rtl/display_scan_driver_if.sv
// Value strobe in, board anode/segment pins and slot tick out.
// master = value source, slave = scan driver.
interface display_scan_driver_if;

    logic [3:0] value_in;
    logic       value_valid;
    logic [6:0] seg;
    logic [1:0] an;
    logic       digit_tick;

    modport master (
        output value_in,
        output value_valid,
        input  seg,
        input  an,
        input  digit_tick
    );

    modport slave (
        input  value_in,
        input  value_valid,
        output seg,
        output an,
        output digit_tick
    );

endinterface

// File: rtl/display_scan_driver_seg7_encoder.sv
// BCD digit to active-high 7-segment code; non-decimal codes go dark.
// Purely combinational; pin polarity is handled by the caller.
module seg7_encoder
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_LUT[0];
            4'd1:    seg_o = SEG_LUT[1];
            4'd2:    seg_o = SEG_LUT[2];
            4'd3:    seg_o = SEG_LUT[3];
            4'd4:    seg_o = SEG_LUT[4];
            4'd5:    seg_o = SEG_LUT[5];
            4'd6:    seg_o = SEG_LUT[6];
            4'd7:    seg_o = SEG_LUT[7];
            4'd8:    seg_o = SEG_LUT[8];
            4'd9:    seg_o = SEG_LUT[9];
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed two-digit common-anode display driver for values 0..15.
// Prescaler paces digit slots; the tens digit is blanked below 10.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scan_driver_if.slave bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    localparam logic [1:0] AN_OFF =
        AN_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic [6:0] SEG_DARK =
        SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    scan_state_t state_q, state_d;
    logic [3:0]    value_q, value_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    logic          wrap;
    logic          tens;
    logic [3:0]    units;
    logic [3:0]    enc_in;
    logic [6:0]    enc_out;
    logic [6:0]    seg_hi;
    logic [1:0]    an_hi;

    assign tens  = tens_of(value_q);
    assign units = units_of(value_q);
    assign wrap  = (cnt_q == CNT_LAST);

    assign enc_in = (state_q == S_TENS) ? {3'b000, tens} : units;

    seg7_encoder u_enc (
        .bcd_i (enc_in),
        .seg_o (enc_out)
    );

    always_comb begin
        value_d = bus.value_valid ? bus.value_in : value_q;
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        tick_d  = wrap;
        state_d = state_q;
        if (wrap) begin
            state_d = (state_q == S_UNITS) ? S_TENS : S_UNITS;
        end
    end

    // Active-high digit/segment selection, then mapped to pin polarity.
    always_comb begin
        an_hi  = 2'b00;
        seg_hi = SEG_BLANK;
        unique case (1'b1)
            (state_q == S_UNITS): begin
                an_hi  = 2'b01;
                seg_hi = enc_out;
            end
            (state_q == S_TENS && tens): begin
                an_hi  = 2'b10;
                seg_hi = enc_out;
            end
            default: begin
                an_hi  = 2'b00;
                seg_hi = SEG_BLANK;
            end
        endcase
        an_d  = AN_ACTIVE_LOW  ? ~an_hi  : an_hi;
        seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_UNITS;
            value_q <= 4'd0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            seg_q   <= SEG_DARK;
            an_q    <= AN_OFF;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.digit_tick = tick_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized + directed bench for display_scan_driver (REFRESH_DIV=4).
// Expected pins come from slot arithmetic over edges since reset.
module tb_display_scan_driver;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    display_scan_driver_if bus ();

    display_scan_driver #(
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int         n    = 0;
    int         mval = 0;
    logic [6:0] e_seg = 7'h7F;
    logic [1:0] e_an  = 2'b11;
    logic       e_tick = 1'b0;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // n = clean edges since reset; state after n edges is slot (n/DIV)%2.
    task automatic model_edge(input bit r, input bit v, input int d);
        bit tens_slot;
        if (r) begin
            n = 0;
            mval = 0;
            e_an = 2'b11;
            e_seg = 7'h7F;
            e_tick = 1'b0;
        end else begin
            tens_slot = ((n / DIV) % 2) == 1;
            if (!tens_slot) begin
                e_an = 2'b10;
                e_seg = ~enc(mval % 10);
            end else if (mval >= 10) begin
                e_an = 2'b01;
                e_seg = ~enc(mval / 10);
            end else begin
                e_an = 2'b11;
                e_seg = 7'h7F;
            end
            n++;
            if (v) mval = d;
            e_tick = (n % DIV) == 0;
        end
    endtask

    task automatic cyc(input bit r, input bit v, input int d);
        rst = r;
        bus.value_valid = v;
        bus.value_in = 4'(d);
        @(posedge clk);
        model_edge(r, v, d);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_until(input int m);
        for (int i = 0; i < 16; i++) begin
            if ((n % (2 * DIV)) == m) return;
            cyc(0, 0, 0);
        end
        checks++;
        errors++;
        $display("FAIL align: n=%0d never reached phase %0d", n, m);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.seg !== e_seg || bus.an !== e_an ||
                bus.digit_tick !== e_tick) begin
                errors++;
                $display("FAIL model n=%0d: seg=%h an=%b tick=%b exp seg=%h an=%b tick=%b",
                         n, bus.seg, bus.an, bus.digit_tick,
                         e_seg, e_an, e_tick);
            end
            checks++;
            if (bus.an === 2'b00) begin
                errors++;
                $display("FAIL an_both: got %b expected not 00",
                         bus.an);
            end
        end
    end

    initial begin
        bus.value_in = 4'd0;
        bus.value_valid = 1'b0;
        cyc(1, 0, 0);
        chk_en = 1'b1;
        cyc(1, 1, 9);
        check("rst_an", {6'd0, bus.an}, 8'h03);
        check("rst_seg", {1'b0, bus.seg}, 8'h7F);

        cyc(0, 0, 0);
        check("idle_an", {6'd0, bus.an}, 8'h02);
        check("idle_seg", {1'b0, bus.seg}, 8'h40);
        check("idle_tick0", {7'd0, bus.digit_tick}, 8'h00);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("first_tick", {7'd0, bus.digit_tick}, 8'h01);
        cyc(0, 0, 0);
        check("blank_an", {6'd0, bus.an}, 8'h03);

        cyc(0, 1, 7);
        run_until(2);
        check("v7_seg", {1'b0, bus.seg}, 8'h78);
        check("v7_an", {6'd0, bus.an}, 8'h02);
        run_until(6);
        check("v7_tens_an", {6'd0, bus.an}, 8'h03);

        cyc(0, 1, 13);
        run_until(2);
        check("v13_u_seg", {1'b0, bus.seg}, 8'h30);
        check("v13_u_an", {6'd0, bus.an}, 8'h02);
        run_until(6);
        check("v13_t_seg", {1'b0, bus.seg}, 8'h79);
        check("v13_t_an", {6'd0, bus.an}, 8'h01);

        // Strobe on the wrap edge into the tens slot.
        cyc(0, 1, 9);
        run_until(3);
        cyc(0, 1, 15);
        cyc(0, 0, 0);
        check("wrap_t_seg", {1'b0, bus.seg}, 8'h79);
        check("wrap_t_an", {6'd0, bus.an}, 8'h01);
        run_until(1);
        check("wrap_u_seg", {1'b0, bus.seg}, 8'h12);

        cyc(0, 1, 12);
        run_until(6);
        cyc(1, 0, 0);
        check("mid_rst_an", {6'd0, bus.an}, 8'h03);
        check("mid_rst_seg", {1'b0, bus.seg}, 8'h7F);
        for (int i = 0; i < DIV; i++) begin
            cyc(0, 0, 5);
            check("post_rst_an", {6'd0, bus.an}, 8'h02);
            check("post_rst_seg", {1'b0, bus.seg}, 8'h40);
        end
        cyc(0, 0, 5);
        check("post_rst_tens", {6'd0, bus.an}, 8'h03);

        for (int i = 0; i < 3 * DIV; i++) begin
            cyc(0, 0, $urandom_range(0, 15));
        end

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) == 0),
                $urandom_range(0, 15));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
